// File: rtl/tile_reg_bank_pkg.sv
// Shared tile-layer register constants: layer/register counts, widths,
// register indices and TILE_CTRL0 bit positions.
package tile_reg_bank_pkg;

  localparam int NUM_TILE_LAYERS = 4;
  localparam int NUM_TILE_REGISTERS = 8;
  localparam int REG_DATA_WIDTH = 16;
  localparam int NUM_REG_BITS_PER_TILE_LAYER =
    NUM_TILE_REGISTERS * REG_DATA_WIDTH;
  localparam int NUM_TOTAL_TILE_REG_BITS =
    NUM_TILE_LAYERS * NUM_REG_BITS_PER_TILE_LAYER;

  typedef enum logic [2:0] {
    TILE_CTRL0     = 3'd0,
    TILE_CTRL1     = 3'd1,
    TILE_SCROLL_X  = 3'd2,
    TILE_SCROLL_Y  = 3'd3,
    TILE_MAP_BASE  = 3'd4,
    TILE_DATA_BASE = 3'd5,
    TILE_OFFSET_X  = 3'd6,
    TILE_OFFSET_Y  = 3'd7
  } tile_reg_e;

  localparam int TILE_CTRL0_ENABLE      = 0;
  localparam int TILE_CTRL0_WRAP_X      = 1;
  localparam int TILE_CTRL0_WRAP_Y      = 2;
  localparam int TILE_CTRL0_FLIP_X      = 3;
  localparam int TILE_CTRL0_FLIP_Y      = 4;
  localparam int TILE_CTRL0_PALETTE_LSB = 8;
  localparam int TILE_CTRL0_PALETTE_MSB = 11;

  function automatic int word_index(input int layer, input int regi);
    return layer * NUM_TILE_REGISTERS + regi;
  endfunction

endpackage

// File: rtl/tile_reg_bank_word.sv
// tile_reg_word: one register with sync reset, byte-enabled write and a
// whole-word load port; nxt exposes the value it will take on a write.
module tile_reg_word #(
  parameter int W = 16
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           wr,
  input  logic [W/8-1:0] be,
  input  logic [W-1:0]   data_in,
  input  logic           load,
  input  logic [W-1:0]   load_data,
  output logic [W-1:0]   q,
  output logic [W-1:0]   nxt
);

  always_comb begin
    nxt = q;
    if (wr) begin
      for (int b = 0; b < W / 8; b++) begin
        if (be[b]) nxt[b*8 +: 8] = data_in[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) q <= '0;
    else if (load) q <= load_data;
    else q <= nxt;
  end

endmodule

// File: rtl/tile_reg_bank.sv
// Tile-layer register bank feeding the packed tile_reg_values bus.
// Define TILE_REG_SHADOW_EN for staging/active banks committed on vblank.
module tile_reg_bank
  import tile_reg_bank_pkg::*;
#(
  parameter int NUM_LAYERS = NUM_TILE_LAYERS,
  parameter int NUM_REGS   = NUM_TILE_REGISTERS,
  parameter int DATA_WIDTH = REG_DATA_WIDTH,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  rd,
  input  logic                  wr,
  input  logic [1:0]            be,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  input  logic                  vblank,
  output logic                  update_pending,
  output logic [NUM_LAYERS*NUM_REGS*DATA_WIDTH-1:0] tile_reg_values
);

  localparam int NUM_WORDS = NUM_LAYERS * NUM_REGS;

  logic                  in_range;
  logic                  wr_ok;
  logic                  rd_ok;
  logic [NUM_WORDS-1:0]  wsel;
  logic [DATA_WIDTH-1:0] stg_q   [NUM_WORDS];
  logic [DATA_WIDTH-1:0] stg_nxt [NUM_WORDS];
  logic [DATA_WIDTH-1:0] act_q   [NUM_WORDS];
  logic [DATA_WIDTH-1:0] rd_word;

  assign in_range = 32'(addr) < NUM_WORDS;
  assign wr_ok    = en & wr & in_range;
  assign rd_ok    = en & rd;

`ifdef TILE_REG_SHADOW_EN
  logic vblank_d;
  logic commit;
  logic [DATA_WIDTH-1:0] unused_act_nxt [NUM_WORDS];

  assign commit = vblank & ~vblank_d;

  // A commit wins over a same-cycle write for the pending flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      vblank_d       <= 1'b0;
      update_pending <= 1'b0;
    end else begin
      vblank_d <= vblank;
      if (commit) update_pending <= 1'b0;
      else if (wr_ok) update_pending <= 1'b1;
    end
  end
`else
  logic unused_vblank;
  logic [DATA_WIDTH-1:0] unused_stg_nxt [NUM_WORDS];

  assign unused_vblank  = vblank;
  assign update_pending = 1'b0;
`endif

  for (genvar k = 0; k < NUM_WORDS; k++) begin : g_word
    assign wsel[k] = wr_ok & (32'(addr) == k);

    tile_reg_word #(.W(DATA_WIDTH)) u_stg (
      .clk       (clk),
      .reset     (reset),
      .wr        (wsel[k]),
      .be        (be),
      .data_in   (data_in),
      .load      (1'b0),
      .load_data ('0),
      .q         (stg_q[k]),
      .nxt       (stg_nxt[k])
    );

`ifdef TILE_REG_SHADOW_EN
    // Loads the staging next-value so a write on the commit edge lands too.
    tile_reg_word #(.W(DATA_WIDTH)) u_act (
      .clk       (clk),
      .reset     (reset),
      .wr        (1'b0),
      .be        ('0),
      .data_in   ('0),
      .load      (commit),
      .load_data (stg_nxt[k]),
      .q         (act_q[k]),
      .nxt       (unused_act_nxt[k])
    );
`else
    assign act_q[k]          = stg_q[k];
    assign unused_stg_nxt[k] = stg_nxt[k];
`endif

    assign tile_reg_values[k*DATA_WIDTH +: DATA_WIDTH] = act_q[k];
  end

  always_comb begin
    rd_word = '0;
    for (int k = 0; k < NUM_WORDS; k++) begin
      if (32'(addr) == k) rd_word = stg_q[k];
    end
  end

  // Reads see the pre-write staging value.
  always_ff @(posedge clk) begin
    if (reset) data_out <= '0;
    else if (rd_ok) data_out <= rd_word;
  end

endmodule

// File: tb/tb_tile_reg_bank.sv
// Scoreboard bench for tile_reg_bank; follows TILE_REG_SHADOW_EN.
// Reads queue their expected word, popped when data_out is due.
module tb_tile_reg_bank;
  import tile_reg_bank_pkg::*;

`ifdef TILE_REG_SHADOW_EN
  localparam bit SHADOW = 1'b1;
`else
  localparam bit SHADOW = 1'b0;
`endif
  localparam int NW = 32;

  logic         clk = 1'b0;
  logic         reset, en, rd, wr, vblank, update_pending;
  logic [1:0]   be;
  logic [7:0]   addr;
  logic [15:0]  data_in, data_out;
  logic [511:0] tile_reg_values;

  always #5 clk = ~clk;

  tile_reg_bank dut (
    .clk             (clk),
    .reset           (reset),
    .en              (en),
    .rd              (rd),
    .wr              (wr),
    .be              (be),
    .addr            (addr),
    .data_in         (data_in),
    .data_out        (data_out),
    .vblank          (vblank),
    .update_pending  (update_pending),
    .tile_reg_values (tile_reg_values)
  );

  logic [15:0] stg [NW];
  logic [15:0] act [NW];
  logic [15:0] sb [$];
  bit pend_m, vbd_m, vb_lvl;
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag,
                       input logic [511:0] got,
                       input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [511:0] pack_act();
    logic [511:0] v;
    for (int k = 0; k < NW; k++) v[k*16 +: 16] = act[k];
    return v;
  endfunction

  task automatic bus(input bit rst, input bit e, input bit r,
                     input bit w, input logic [1:0] b, input int a,
                     input logic [15:0] d, input bit vb);
    bit rise, wok, rok;
    logic [15:0] m;
    reset = rst; en = e; rd = r; wr = w;
    be = b; addr = 8'(a); data_in = d; vblank = vb;
    rok = e & r & !rst;
    wok = e & w & (a < NW);
    if (rok) sb.push_back(a < NW ? stg[a] : 16'h0);
    @(posedge clk);
    #1;
    if (rst) begin
      for (int k = 0; k < NW; k++) begin
        stg[k] = '0;
        act[k] = '0;
      end
      pend_m = 1'b0;
      vbd_m  = 1'b0;
    end else begin
      rise = vb & ~vbd_m;
      if (wok) begin
        m = stg[a];
        if (b[0]) m[7:0] = d[7:0];
        if (b[1]) m[15:8] = d[15:8];
        stg[a] = m;
      end
      if (SHADOW) begin
        if (rise) begin
          for (int k = 0; k < NW; k++) act[k] = stg[k];
          pend_m = 1'b0;
        end else if (wok) pend_m = 1'b1;
      end else begin
        for (int k = 0; k < NW; k++) act[k] = stg[k];
      end
      vbd_m = vb;
      if (rok) check("rd", 512'(data_out), 512'(sb.pop_front()));
    end
    check("act", tile_reg_values, pack_act());
    check("pend", 512'(update_pending), 512'(pend_m));
  endtask

  task automatic idle();
    bus(0, 0, 0, 0, 2'b00, 0, 16'h0, vb_lvl);
  endtask

  task automatic write(input int a, input logic [15:0] d,
                       input logic [1:0] b);
    bus(0, 1, 0, 1, b, a, d, vb_lvl);
  endtask

  task automatic read(input int a);
    bus(0, 1, 1, 0, 2'b00, a, 16'h0, vb_lvl);
  endtask

  initial begin
    vb_lvl = 1'b0;
    bus(1, 0, 0, 0, 2'b00, 0, 16'h0, 0);
    bus(1, 0, 0, 0, 2'b00, 0, 16'h0, 0);
    check("rst_dout", 512'(data_out), 512'h0);
    check("rst_tile", tile_reg_values, 512'h0);

    for (int a = 0; a < NW; a++) read(a);

    write(word_index(2, 5), 16'hA5C3, 2'b11);
    read(word_index(2, 5));
    check("t2_dout", 512'(data_out), 512'hA5C3);
    check("t2_pend", 512'(update_pending), 512'(SHADOW));
    check("t2_pre", 512'(tile_reg_values[(2*8+5)*16 +: 16]),
          SHADOW ? 512'h0 : 512'hA5C3);
    vb_lvl = 1'b1; idle();
    vb_lvl = 1'b0; idle();
    check("t2_post", 512'(tile_reg_values[(2*8+5)*16 +: 16]),
          512'hA5C3);
    check("t2_pclr", 512'(update_pending), 512'h0);

    write(10, 16'h1234, 2'b11);
    write(10, 16'hFFEE, 2'b10);
    read(10);
    check("t3_hi", 512'(data_out), 512'hFF34);
    write(10, 16'h0000, 2'b01);
    read(10);
    check("t3_lo", 512'(data_out), 512'hFF00);

    vb_lvl = 1'b1;
    write(0, 16'h0001, 2'b11);
    check("t4_slice", 512'(tile_reg_values[15:0]), 512'h1);
    check("t4_pend", 512'(update_pending), 512'h0);
    for (int i = 0; i < 10; i++) begin
      if (i == 4) write(1, 16'h0055, 2'b11);
      else idle();
    end
    check("t4_hold", 512'(update_pending), 512'(SHADOW));
    check("t4_nocm", 512'(tile_reg_values[31:16]),
          SHADOW ? 512'h0 : 512'h55);
    vb_lvl = 1'b0; idle();

    write(3, 16'h0007, 2'b11);
    bus(0, 1, 1, 1, 2'b11, 3, 16'h0009, vb_lvl);
    check("t5_old", 512'(data_out), 512'h7);
    read(3);
    check("t5_new", 512'(data_out), 512'h9);
    write(32, 16'hDEAD, 2'b11);
    read(32);
    check("t5_oor", 512'(data_out), 512'h0);

    write(7, 16'h7777, 2'b11);
    bus(1, 1, 0, 1, 2'b11, 5, 16'hBEEF, 0);
    check("t6_tile", tile_reg_values, 512'h0);
    check("t6_pend", 512'(update_pending), 512'h0);
    read(7);
    read(5);
    write(4, 16'h4444, 2'b11);
    check("t6_vis", 512'(tile_reg_values[4*16 +: 16]),
          SHADOW ? 512'h0 : 512'h4444);
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
